uart_rx_param: RTL
==================

# uart_rx_param

Parametrised UART receive core: it recovers frames from the asynchronous serial line `rx` using an oversampled baud tick. It supports a configurable data width, an optional even/odd parity bit and 1 or 2 stop bits. Each received word is presented on a valid/ready holding register together with parity and framing status. Overrun is reported on a sticky flag. The block sits between the pad-side serial input and the bus-side register/FIFO logic, and supersedes the fixed-frame receiver.

## Interface
- `DATA_W`, default 8: data bits per frame, legal range 5..9.
- `OVERSAMPLE`, default 16: ticks per bit period; even, at least 4.
- `DIV_W`, default 16: width of the baud divisor.
- `clk` input, 1 bit: single clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `baud_div` input, DIV_W bits: clock cycles per oversample tick, minus 1.
- `parity_en` input, 1 bit: a parity bit follows the data bits.
- `parity_odd` input, 1 bit: 1 selects odd parity, 0 selects even.
- `two_stop` input, 1 bit: expect two stop bits.
- `rx` input, 1 bit: asynchronous serial line; idles high.
- `out_ready` input, 1 bit: consumer accepts the held word.
- `err_clr` input, 1 bit: clears `overrun_err`.
- `out_data` output, DATA_W bits: received word, LSB = first bit on the line.
- `out_valid` output, 1 bit: the holding register is full.
- `parity_err` output, 1 bit: parity mismatch for the held word.
- `frame_err` output, 1 bit: a stop bit was sampled low for the held word.
- `overrun_err` output, 1 bit: sticky; a frame completed while `out_valid` was high and `out_ready` was low.
- `busy` output, 1 bit: the FSM is not in IDLE.

## Operation
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser, both flops reset to 1. All decisions use the synchronised value `rxs`.
- **Tick generator:**
  - Down-counter reloads `baud_div`; `tick` is high for 1 cycle when the count reaches 0.
  - With `baud_div=0`, `tick` is high every cycle.
  - The counter is reloaded on start detection so that bit sampling is phase-aligned.
- **Configuration latch:** `parity_en`, `parity_odd` and `two_stop` are latched on start detection. Changes mid-frame have no effect.
- **FSM states:** IDLE, START, DATA, PARITY, STOP1, STOP2, BRK.
  - **IDLE:** `rxs==0` -> START; clear the tick phase counter `ph` and the bit counter.
  - **START:** when `ph` reaches OVERSAMPLE/2-1 on a tick, sample `rxs`.
    - Sample = 1: false start -> IDLE, no output.
    - Sample = 0: -> DATA, with `ph` cleared.
  - **DATA:** sample on every OVERSAMPLE-th tick (mid-bit). Shift the bit into a shift register, LSB first. After DATA_W bits -> PARITY if parity is enabled, else STOP1.
  - **PARITY:** sample the parity bit.
    - Error if `sample != (^data ^ parity_odd)`.
    - For even parity the XOR of data plus parity must be 0; for odd parity it must be 1.
  - **STOP1:** sample. -> STOP2 if `two_stop`, else complete the frame.
  - **STOP2:** sample, then complete the frame.
  - **BRK:** entered when any stop sample is 0; wait for `rxs==1`, then -> IDLE.
- **Frame completion when the holding register is free** (`!out_valid`, or `out_ready` high in the same cycle):
  - Load `out_data`, `parity_err` and `frame_err`.
  - Set `out_valid`.
- **Frame completion when the holding register is occupied:**
  - Discard the new word and keep the old one.
  - Set `overrun_err`.
- **Leaving the FSM after completion:** -> IDLE, or -> BRK if any stop sample was 0.
- **Handshake:** `out_valid && out_ready` clears `out_valid` on the next edge. Data and status remain stable while `out_valid` is high.
- **Simultaneous events:**
  - Completion and `out_ready` in the same cycle: the new word loads and `out_valid` stays 1.
  - `err_clr` and a new overrun in the same cycle: the overrun wins and the flag stays 1.
- **Reset values:** `out_data=0`, `out_valid=0`, `parity_err=0`, `frame_err=0`, `overrun_err=0`, `busy=0`; FSM in IDLE; synchroniser at 1.
- **Reset mid-frame:** the partial frame is dropped and the block returns to IDLE.

## Timing
- 1 bit period = OVERSAMPLE × (`baud_div`+1) clocks.
- Start is recognised 2 cycles after the line falls, due to the synchroniser.
- Sampling points sit at the bit centre ± 1 tick.
- `out_valid` rises 1 clock after the final stop-bit sample.
- Back-to-back frames with no idle gap are received without loss in 1-stop mode.
- Tolerated baud mismatch: ±3% at OVERSAMPLE=16.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state encoding (3 bits).
  - Parity mode constants.
  - Default OVERSAMPLE and DIV_W, shared with the transmitter.
- **Sub-module `uart_baud_tick`:** parameter DIV_W, inputs `clk`, `reset`, `baud_div`, `resync`, output `tick`. It is reused by the transmit side.
- The synchroniser, FSM, shift register and holding register live in `uart_rx_param`.

## Test plan
All scenarios use `baud_div=0`, OVERSAMPLE=16 (16 clocks per bit), DATA_W=8.

- **8N1, word 0xA5:**
  - `out_ready=1` -> `out_data=0xA5` with `out_valid` pulsed for 1 cycle.
  - `parity_err=0`, `frame_err=0`.
  - `out_valid` rises 16×9.5+3 ±1 clocks after the start edge.
- **Parity:**
  - 8E1, word 0x03, parity bit 0 -> `parity_err=0`.
  - The same frame with parity bit 1 -> `parity_err=1`, `out_data=0x03`.
- **Framing and break:**
  - Stop bit driven low -> `frame_err=1`; FSM waits in BRK while `rx=0` and ignores the line.
  - `rx` high, then a 0x5A frame -> 0x5A received cleanly.
- **Glitch rejection:** a 4-clock low pulse on idle `rx` -> no `out_valid`, `busy` returns to 0.
- **Overrun:**
  - With `out_ready=0`, send 0x11 then 0x22 -> `out_data` stays 0x11 and `overrun_err=1`.
  - `err_clr` clears `overrun_err`.
  - `out_ready` then pops 0x11.
- **Reset mid-frame:** assert `reset` during data bit 4 -> all outputs 0; a following 2-stop frame of 0xFF (`two_stop=1`) is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity modes, frame configuration
// and the defaults shared by the receive and transmit cores.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_BRK    = 3'd6
  } uart_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_e;

  // Frame format captured when a start bit is detected.
  typedef struct packed {
    logic         parity_en;
    parity_mode_e parity_mode;
    logic         two_stop;
  } uart_cfg_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DIV_W      = 16;

endpackage

// File: rtl/uart_rx_param_if.sv
// Bus-side holding-register handshake of the UART receiver.
interface uart_rx_param_if
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun_err;
  logic              err_clr;

  modport master (
    output out_data, out_valid, parity_err, frame_err, overrun_err,
    input  out_ready, err_clr
  );

  modport slave (
    input  out_data, out_valid, parity_err, frame_err, overrun_err,
    output out_ready, err_clr
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every baud_div+1 clocks,
// re-phased on demand so sampling lines up with a detected start edge.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV_W = UART_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             resync,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Down-counter, reloaded on expiry or on resync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (resync || cnt == '0) begin
      cnt <= baud_div;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, oversampling frame FSM,
// shift register and valid/ready holding register with error status.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DIV_W      = UART_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
  input  logic             rx,
  uart_rx_param_if.master  ob,
  output logic             busy
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_END  = PH_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  logic              rx_p0, rx_p1, rxs;
  logic              tick, resync, cfg_load, bit_pt, slot_free;
  logic              done, done_ferr;
  uart_state_e       state, state_n;
  uart_cfg_t         cfg;
  logic [PH_W-1:0]   ph, ph_n;
  logic [BC_W-1:0]   bcnt, bcnt_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic              perr_acc, perr_n, ferr_acc, ferr_n;

  assign rxs       = rx_p1;
  assign bit_pt    = tick && (ph == PH_END);
  assign busy      = (state != ST_IDLE);
  assign slot_free = !ob.out_valid || ob.out_ready;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .baud_div (baud_div),
    .resync   (resync),
    .tick     (tick)
  );

  // Two-flop synchroniser on the asynchronous line, idling high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  // Frame FSM next-state, bit phase and sampling decisions.
  always_comb begin
    state_n   = state;
    ph_n      = ph;
    bcnt_n    = bcnt;
    sh_n      = sh;
    perr_n    = perr_acc;
    ferr_n    = ferr_acc;
    resync    = 1'b0;
    cfg_load  = 1'b0;
    done      = 1'b0;
    done_ferr = ferr_acc;
    if (state != ST_IDLE && state != ST_START && state != ST_BRK && tick) begin
      ph_n = (ph == PH_END) ? '0 : ph + 1'b1;
    end
    case (state)
      ST_IDLE: begin
        if (!rxs) begin
          state_n  = ST_START;
          ph_n     = '0;
          bcnt_n   = '0;
          perr_n   = 1'b0;
          ferr_n   = 1'b0;
          resync   = 1'b1;
          cfg_load = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (ph == PH_MID) begin
            ph_n    = '0;
            state_n = rxs ? ST_IDLE : ST_DATA;
          end else begin
            ph_n = ph + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (bit_pt) begin
          sh_n   = {rxs, sh[DATA_W-1:1]};
          bcnt_n = bcnt + 1'b1;
          if (bcnt == BC_LAST) begin
            state_n = cfg.parity_en ? ST_PARITY : ST_STOP1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_pt) begin
          perr_n  = rxs != ((^sh) ^ (cfg.parity_mode == PAR_ODD));
          state_n = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (bit_pt) begin
          if (cfg.two_stop) begin
            ferr_n  = !rxs;
            state_n = ST_STOP2;
          end else begin
            done      = 1'b1;
            done_ferr = !rxs;
            state_n   = rxs ? ST_IDLE : ST_BRK;
          end
        end
      end
      ST_STOP2: begin
        if (bit_pt) begin
          done      = 1'b1;
          done_ferr = ferr_acc | !rxs;
          state_n   = done_ferr ? ST_BRK : ST_IDLE;
        end
      end
      ST_BRK: begin
        if (rxs) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM control registers and configuration latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ph       <= '0;
      bcnt     <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
      cfg      <= '0;
    end else begin
      state    <= state_n;
      ph       <= ph_n;
      bcnt     <= bcnt_n;
      perr_acc <= perr_n;
      ferr_acc <= ferr_n;
      if (cfg_load) cfg <= '{parity_en, parity_mode_e'(parity_odd), two_stop};
    end
  end

  // Receive shift register (pure datapath, no reset needed).
  always_ff @(posedge clk) begin
    sh <= sh_n;
  end

  // Holding register, handshake and sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ob.out_data    <= '0;
      ob.out_valid   <= 1'b0;
      ob.parity_err  <= 1'b0;
      ob.frame_err   <= 1'b0;
      ob.overrun_err <= 1'b0;
    end else begin
      if (done && slot_free) begin
        ob.out_data   <= sh;
        ob.parity_err <= perr_acc;
        ob.frame_err  <= done_ferr;
        ob.out_valid  <= 1'b1;
      end else if (ob.out_valid && ob.out_ready) begin
        ob.out_valid  <= 1'b0;
      end
      if (done && !slot_free) begin
        ob.overrun_err <= 1'b1;
      end else if (ob.err_clr) begin
        ob.overrun_err <= 1'b0;
      end
    end
  end

endmodule
